// File: rtl/dii_packet_fifo.sv
// Circular-buffer FIFO for dii_flit streams with occupancy/packet counters, head-packet
// length tracking, synchronous flush and oversize-packet recovery in full-packet mode.
package dii_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module dii_packet_fifo
  import dii_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter bit FULLPACKET = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  dii_flit                flit_in,
  output logic                   flit_in_ready,
  output dii_flit                flit_out,
  input  logic                   flit_out_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [$clog2(DEPTH):0] packet_count,
  output logic [$clog2(DEPTH):0] packet_size,
  output logic                   oversize
);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   ONE  = 1;
  localparam logic [AW-1:0] LONE = 1;

  logic [AW:0]   r_wp, r_rp, r_in_len, r_pcnt;
  logic [AW-1:0] r_lwp, r_lrp;
  logic [16:0]   r_ram [DEPTH];
  logic [AW:0]   r_len [DEPTH];
  logic          r_forced, r_taint, r_oversize;

  logic w_full, w_empty, w_push, w_pop, w_push_cnt, w_pop_cnt, w_force;

  assign w_full        = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign w_empty       = (r_wp == r_rp);
  assign flit_in_ready = !w_full && !flush;
  assign w_push        = flit_in.valid && flit_in_ready;

  always_comb begin
    flit_out.valid = !w_empty && (!FULLPACKET || (r_pcnt != '0) || r_forced);
    flit_out.last  = r_ram[r_rp[AW-1:0]][16];
    flit_out.data  = r_ram[r_rp[AW-1:0]][15:0];
  end

  assign w_pop      = flit_out.valid && flit_out_ready;
  // Tainted (forced) packets are never counted; while forced, the head is always the forced packet.
  assign w_push_cnt = w_push && flit_in.last && !r_taint;
  assign w_pop_cnt  = w_pop && flit_out.last && !r_forced;
  assign w_force    = FULLPACKET && w_full && (r_pcnt == '0) && !r_forced;

  assign occupancy    = r_wp - r_rp;
  assign packet_count = r_pcnt;
  assign packet_size  = (FULLPACKET && (r_pcnt != '0)) ? r_len[r_lrp] : '0;
  assign oversize     = r_oversize;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_in_len   <= '0;
      r_pcnt     <= '0;
      r_lwp      <= '0;
      r_lrp      <= '0;
      r_forced   <= 1'b0;
      r_taint    <= 1'b0;
      r_oversize <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + ONE;
      if (w_pop)  r_rp <= r_rp + ONE;
      if (w_push) begin
        if (flit_in.last) begin
          r_in_len <= '0;
          r_taint  <= 1'b0;
        end else begin
          r_in_len <= r_in_len + ONE;
        end
      end
      // Forcing only happens when full, so it never coincides with a push.
      if (w_force) r_taint <= 1'b1;
      r_oversize <= w_force;
      if (w_force)                                   r_forced <= 1'b1;
      else if (w_pop && flit_out.last && r_forced)   r_forced <= 1'b0;
      if (w_push_cnt) r_lwp <= r_lwp + LONE;
      if (w_pop_cnt)  r_lrp <= r_lrp + LONE;
      case ({w_push_cnt, w_pop_cnt})
        2'b10:   r_pcnt <= r_pcnt + ONE;
        2'b01:   r_pcnt <= r_pcnt - ONE;
        default: r_pcnt <= r_pcnt;
      endcase
    end
  end

  // Storage arrays carry no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push)     r_ram[r_wp[AW-1:0]] <= {flit_in.last, flit_in.data};
    if (w_push_cnt) r_len[r_lwp]        <= r_in_len + ONE;
  end
endmodule

// File: tb/tb_dii_packet_fifo.sv
// Randomized bench: a cut-through instance (DEPTH=8) and a full-packet instance (DEPTH=4)
// share one stimulus stream and are compared each cycle against a queue-based packet model.
module tb_dii_packet_fifo;
  import dii_pkg::*;

  localparam int D0 = 8;
  localparam int D1 = 4;

  logic    clk = 1'b0;
  logic    rst, flush, out_ready;
  dii_flit fin;
  dii_flit fo0, fo1;
  logic    ir0, ir1, ov0, ov1;
  logic [3:0] occ0, pc0, ps0;
  logic [2:0] occ1, pc1, ps1;

  always #5 clk = ~clk;

  dii_packet_fifo #(.DEPTH(D0), .FULLPACKET(1'b0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .flit_in(fin), .flit_in_ready(ir0),
    .flit_out(fo0), .flit_out_ready(out_ready), .occupancy(occ0),
    .packet_count(pc0), .packet_size(ps0), .oversize(ov0));

  dii_packet_fifo #(.DEPTH(D1), .FULLPACKET(1'b1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .flit_in(fin), .flit_in_ready(ir1),
    .flit_out(fo1), .flit_out_ready(out_ready), .occupancy(occ1),
    .packet_count(pc1), .packet_size(ps1), .oversize(ov1));

  logic [31:0] a_vld[2], a_rdy[2], a_occ[2], a_pc[2], a_ps[2], a_ov[2], a_data[2], a_last[2];
  assign a_vld[0] = 32'(fo0.valid);  assign a_vld[1] = 32'(fo1.valid);
  assign a_rdy[0] = 32'(ir0);        assign a_rdy[1] = 32'(ir1);
  assign a_occ[0] = 32'(occ0);       assign a_occ[1] = 32'(occ1);
  assign a_pc[0]  = 32'(pc0);        assign a_pc[1]  = 32'(pc1);
  assign a_ps[0]  = 32'(ps0);        assign a_ps[1]  = 32'(ps1);
  assign a_ov[0]  = 32'(ov0);        assign a_ov[1]  = 32'(ov1);
  assign a_data[0] = 32'(fo0.data);  assign a_data[1] = 32'(fo1.data);
  assign a_last[0] = 32'(fo0.last);  assign a_last[1] = 32'(fo1.last);

  // Model: stored flits in order; each flit remembers whether it belongs to a forced packet,
  // and a last flit remembers the full length of its packet.
  typedef struct {
    logic [15:0] data;
    bit          last;
    bit          taint;
    int          len;
  } ent_t;

  ent_t mq [2][$];
  bit   mtaint [2];
  int   minlen [2];
  bit   movs   [2];

  int nchk = 0;
  int nerr = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mdepth(int k);
    return (k == 0) ? D0 : D1;
  endfunction

  function automatic bit mfp(int k);
    return k == 1;
  endfunction

  function automatic int mpcnt(int k);
    int n = 0;
    for (int i = 0; i < mq[k].size(); i++)
      if (mq[k][i].last && !mq[k][i].taint) n++;
    return n;
  endfunction

  function automatic bit mforced(int k);
    if (mtaint[k]) return 1'b1;
    for (int i = 0; i < mq[k].size(); i++)
      if (mq[k][i].taint) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int msize(int k);
    if (!mfp(k)) return 0;
    for (int i = 0; i < mq[k].size(); i++)
      if (mq[k][i].last && !mq[k][i].taint) return mq[k][i].len;
    return 0;
  endfunction

  function automatic bit mvalid(int k);
    if (mq[k].size() == 0) return 1'b0;
    return !mfp(k) || (mpcnt(k) > 0) || mforced(k);
  endfunction

  function automatic bit mready(int k);
    return (mq[k].size() < mdepth(k)) && !flush;
  endfunction

  task automatic check_inst(int k);
    chk($sformatf("u%0d.valid", k),    a_vld[k], 32'(mvalid(k)));
    chk($sformatf("u%0d.in_ready", k), a_rdy[k], 32'(mready(k)));
    chk($sformatf("u%0d.occupancy", k), a_occ[k], 32'(mq[k].size()));
    chk($sformatf("u%0d.pkt_count", k), a_pc[k], 32'(mpcnt(k)));
    chk($sformatf("u%0d.pkt_size", k),  a_ps[k], 32'(msize(k)));
    chk($sformatf("u%0d.oversize", k),  a_ov[k], 32'(movs[k]));
    if (mvalid(k)) begin
      chk($sformatf("u%0d.data", k), a_data[k], 32'(mq[k][0].data));
      chk($sformatf("u%0d.last", k), a_last[k], 32'(mq[k][0].last));
    end
  endtask

  task automatic model_step(int k);
    bit   push, pop, frc;
    ent_t e;
    push = fin.valid && mready(k);
    pop  = mvalid(k) && out_ready;
    if (!rst || flush) begin
      mq[k].delete();
      mtaint[k] = 1'b0;
      minlen[k] = 0;
      movs[k]   = 1'b0;
      return;
    end
    frc = mfp(k) && (mq[k].size() == mdepth(k)) && (mpcnt(k) == 0) && !mforced(k);
    movs[k] = frc;
    if (frc) begin
      // everything stored belongs to the unfinished input packet
      mtaint[k] = 1'b1;
      for (int i = 0; i < mq[k].size(); i++) mq[k][i].taint = 1'b1;
    end
    if (pop) void'(mq[k].pop_front());
    if (push) begin
      minlen[k]++;
      e.data  = fin.data;
      e.last  = fin.last;
      e.taint = mtaint[k];
      e.len   = minlen[k];
      mq[k].push_back(e);
      if (fin.last) begin
        minlen[k] = 0;
        mtaint[k] = 1'b0;
      end
    end
  endtask

  function automatic bit pct(int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic run_phase(int cycles, int pv, int pl, int pr, int pf, int prst);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rst       = !pct(prst);
      flush     = pct(pf);
      fin.valid = pct(pv);
      fin.last  = pct(pl);
      fin.data  = 16'($urandom);
      out_ready = pct(pr);
      #1;
      check_inst(0);
      check_inst(1);
      model_step(0);
      model_step(1);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0; fin = '0;
    for (int k = 0; k < 2; k++) begin
      mtaint[k] = 1'b0; minlen[k] = 0; movs[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    run_phase(3,   50, 50,   0,  0, 100);  // held in reset: reset values
    run_phase(30,  90, 10,   0,  0, 0);    // fill with long packets, stall output
    run_phase(60,  70, 30,  60,  0, 0);
    run_phase(60, 100, 100, 100, 0, 0);    // single-flit packets, wrap pointers
    run_phase(40, 100, 5,    0,  0, 0);    // oversize packets behind a stall
    run_phase(40,  80, 5,   70,  0, 0);
    run_phase(120, 60, 15,  40,  5, 3);    // flush and reset mid-traffic
    run_phase(200, 50, 20,  50,  3, 2);
    run_phase(40,   0, 20, 100,  0, 0);    // drain
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
